// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store responder: access size
// codes, FSM state encodings and byte-lane helper functions.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Byte-lane enable for an access of 'size' starting at lane 'offset'.
   // Lanes that would fall past lane 7 are dropped by the 8-bit shift.
   function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
      logic [7:0] m;
      case (size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << offset;
   endfunction

   // Clears the offset bits below the natural alignment of 'size'.
   function automatic logic [2:0] align_down(input logic [1:0] size, input logic [2:0] offset);
      logic [2:0] o;
      case (size)
         SZ_B:    o = offset;
         SZ_H:    o = {offset[2:1], 1'b0};
         SZ_W:    o = {offset[2], 2'b00};
         default: o = 3'b000;
      endcase
      return o;
   endfunction

   // True when 'offset' is not a multiple of the access size in bytes.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
      logic r;
      case (size)
         SZ_B:    r = 1'b0;
         SZ_H:    r = offset[0];
         SZ_W:    r = |offset[1:0];
         default: r = |offset;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Load data formatter: picks the addressed byte lanes out of a 64-bit
// doubleword and sign- or zero-extends them to 64 bits.
module load_extend
   import lsu_pkg::*;
(
   input  logic [63:0] dword,
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [63:0] data
);

   logic [63:0] shifted;

   assign shifted = dword >> {offset, 3'b000};

   // Extend the low lanes of the shifted doubleword according to size.
   always_comb begin
      data = shifted;
      case (size)
         SZ_B:    data = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
         SZ_H:    data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
         SZ_W:    data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/data_mem_lsu.sv
// Data-memory responder for the register bank's load/store path.
// One outstanding request; the access completes LATENCY cycles after the
// accept cycle with a single-cycle resp_valid pulse.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses are suppressed
// and flagged on resp_err. Without it, accesses are aligned down and
// resp_err stays 0.
// Assumes ADDR_W > $clog2(MEM_WORDS) + 3.
module data_mem_lsu
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 16,
   parameter int LATENCY   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic              resp_valid,
   output logic              resp_we_reg,
   output logic [4:0]        resp_rd,
   output logic [63:0]       resp_rdata,
   output logic              resp_err
);

   localparam int IDX_W     = $clog2(MEM_WORDS);
   localparam int CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam int WAIT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
   localparam bit SKIP_WAIT = (LATENCY == 1);

   state_e            state;
   logic [CNT_W-1:0]  cnt;
   logic              err_q;

   logic              cap_we;
   logic [1:0]        cap_size;
   logic              cap_unsigned;
   logic [ADDR_W-1:0] cap_addr;
   logic [63:0]       cap_wdata;
   logic [4:0]        cap_rd;

   logic [63:0]       mem [MEM_WORDS];

   logic              accept;
   logic              enter_resp;
   logic              eff_we;
   logic [1:0]        eff_size;
   logic              eff_unsigned;
   logic [ADDR_W-1:0] eff_addr;
   logic [63:0]       eff_wdata;
   logic [4:0]        eff_rd;
   logic [2:0]        acc_off;
   logic              acc_err;
   logic [IDX_W-1:0]  idx;
   logic [63:0]       rd_dword;
   logic [63:0]       ext_data;
   logic              wr_en;
   logic [7:0]        wr_mask;
   logic [63:0]       wr_data;
   logic              unused_addr;

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign resp_err  = err_q;

   // Access fields come straight from the request when completing in the
   // accept cycle (LATENCY=1), otherwise from the captured copy.
   always_comb begin
      eff_we       = cap_we;
      eff_size     = cap_size;
      eff_unsigned = cap_unsigned;
      eff_addr     = cap_addr;
      eff_wdata    = cap_wdata;
      eff_rd       = cap_rd;
      if (state == ST_IDLE) begin
         eff_we       = req_we;
         eff_size     = req_size;
         eff_unsigned = req_unsigned;
         eff_addr     = req_addr;
         eff_wdata    = req_wdata;
         eff_rd       = req_rd;
      end
   end

   assign enter_resp = ((state == ST_IDLE) && accept && SKIP_WAIT) ||
                       ((state == ST_WAIT) && (cnt == '0));

`ifdef MISALIGN_TRAP_EN
   assign acc_off = eff_addr[2:0];
   assign acc_err = is_misaligned(eff_size, eff_addr[2:0]);
`else
   assign acc_off = align_down(eff_size, eff_addr[2:0]);
   assign acc_err = 1'b0;
`endif

   // Doubleword index wraps modulo the memory depth; upper address bits ignored.
   assign idx         = eff_addr[IDX_W+2:3];
   assign unused_addr = ^eff_addr[ADDR_W-1:IDX_W+3];
   assign rd_dword    = mem[idx];

   load_extend u_load_extend (
      .dword       (rd_dword),
      .offset      (acc_off),
      .size        (eff_size),
      .is_unsigned (eff_unsigned),
      .data        (ext_data)
   );

   assign wr_en   = enter_resp && eff_we && !acc_err && !rst;
   assign wr_mask = byte_mask(eff_size, acc_off);
   assign wr_data = eff_wdata << {acc_off, 3'b000};

   // Store byte lanes on the edge entering RESP; memory is never reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (wr_en && wr_mask[b]) begin
            mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   // Request FSM, latency counter and registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         resp_valid  <= 1'b0;
         resp_we_reg <= 1'b0;
         resp_rd     <= '0;
         resp_rdata  <= '0;
         err_q       <= 1'b0;
      end else begin
         resp_valid  <= 1'b0;
         resp_we_reg <= 1'b0;
         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_rd    <= eff_rd;
            err_q      <= acc_err;
            if (eff_we || acc_err) begin
               resp_rdata <= '0;
            end else begin
               resp_rdata  <= ext_data;
               resp_we_reg <= (eff_rd != 5'd0);
            end
         end
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cap_we       <= req_we;
                  cap_size     <= req_size;
                  cap_unsigned <= req_unsigned;
                  cap_addr     <= req_addr;
                  cap_wdata    <= req_wdata;
                  cap_rd       <= req_rd;
                  if (SKIP_WAIT) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_W'(WAIT_INIT);
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
